// File: rtl/race_domain_if.sv
// race_domain_if: groups the button inputs and all registered status
// outputs of race_domain_core into one bundle.
//   btn           player button levels (synchronised, debounced)
//   ready         player i has joined the current race
//   cur_pos       player i position in bits [i*PW +: PW]
//   screen        0=MENU, 1=COUNTDOWN, 2=GAME, 3=END
//   countdown     countdown value, 0 outside COUNTDOWN
//   winner        index of winning player
//   winner_valid  winner is meaningful (END only)
//   activity      one-cycle pulse per accepted press
//   menu_activity one-cycle pulse per screen change / countdown step
// slave: the core side; master: the side driving buttons.
interface race_domain_if #(
  parameter int NUM_PLAYERS = 4,
  parameter int PW          = 4,
  parameter int WW          = 2
);
  logic [NUM_PLAYERS-1:0]    btn;
  logic [NUM_PLAYERS-1:0]    ready;
  logic [NUM_PLAYERS*PW-1:0] cur_pos;
  logic [1:0]                screen;
  logic [2:0]                countdown;
  logic [WW-1:0]             winner;
  logic                      winner_valid;
  logic [NUM_PLAYERS-1:0]    activity;
  logic                      menu_activity;

  modport slave (
    input  btn,
    output ready, cur_pos, screen, countdown, winner, winner_valid,
           activity, menu_activity
  );

  modport master (
    output btn,
    input  ready, cur_pos, screen, countdown, winner, winner_valid,
           activity, menu_activity
  );
endinterface

// File: rtl/race_domain_core.sv
// race_domain_core: button-race game sequencer. Players join in MENU,
// a countdown runs, players race by pressing buttons in GAME, and the
// winner is shown in END before a soft reset back to MENU.
// Ports:
//   clk    single clock, rising edge
//   reset  asynchronous active-low reset
//   bus    race_domain_if.slave (btn in, all status out, all registered)
//
// state        | meaning
// S_MENU       | players join; timer runs once anyone has joined
// S_COUNTDOWN  | countdown steps every MENU_TIMER_CLK_COUNT cycles
// S_GAME       | ready players advance one position per press
// S_END        | winner shown for END_TIMER_CLK_COUNT cycles
module race_domain_core #(
  parameter int NUM_PLAYERS          = 4,
  parameter int MAX_POS              = 16,
  parameter int MENU_TIMER_CLK_COUNT = 50000000,
  parameter int END_TIMER_CLK_COUNT  = 750000000,
  parameter int COUNTDOWN_START      = 3
) (
  input logic         clk,
  input logic         reset,
  race_domain_if.slave bus
);
  localparam int PW   = $clog2(MAX_POS);
  localparam int WW   = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int TMAX = (MENU_TIMER_CLK_COUNT > END_TIMER_CLK_COUNT) ?
                        MENU_TIMER_CLK_COUNT : END_TIMER_CLK_COUNT;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    S_MENU      = 2'd0,
    S_COUNTDOWN = 2'd1,
    S_GAME      = 2'd2,
    S_END       = 2'd3
  } state_t;

  state_t                          state_q, state_d;
  logic [NUM_PLAYERS-1:0]          ready_q, ready_d;
  logic [NUM_PLAYERS-1:0][PW-1:0]  pos_q, pos_d;
  logic [2:0]                      countdown_q, countdown_d;
  logic [WW-1:0]                   winner_q, winner_d;
  logic                            winner_valid_q, winner_valid_d;
  logic [NUM_PLAYERS-1:0]          activity_q, activity_d;
  logic                            menu_act_q, menu_act_d;
  logic [TW-1:0]                   timer_q, timer_d;
  logic [NUM_PLAYERS-1:0]          btn_prev_q;
  logic [NUM_PLAYERS-1:0]          press;
  logic [NUM_PLAYERS-1:0]          accepted;
  logic                            win_found;
  logic                            go_countdown;

  assign press = bus.btn & ~btn_prev_q;

  always_comb begin
    state_d        = state_q;
    ready_d        = ready_q;
    pos_d          = pos_q;
    countdown_d    = countdown_q;
    winner_d       = winner_q;
    winner_valid_d = winner_valid_q;
    activity_d     = '0;
    menu_act_d     = 1'b0;
    timer_d        = timer_q;
    accepted       = '0;
    win_found      = 1'b0;
    go_countdown   = 1'b0;

    case (state_q)
      S_MENU: begin
        accepted = press & ~ready_q;
        // A full lobby starts immediately; otherwise a new join restarts
        // the idle timer so the lobby waits for late joiners.
        if (ready_q == '1) begin
          go_countdown = 1'b1;
        end else if (accepted != '0) begin
          ready_d    = ready_q | accepted;
          activity_d = accepted;
          timer_d    = '0;
        end else if (ready_q != '0) begin
          if (timer_q == TW'(MENU_TIMER_CLK_COUNT - 1)) go_countdown = 1'b1;
          else timer_d = timer_q + TW'(1);
        end
        if (go_countdown) begin
          state_d     = S_COUNTDOWN;
          countdown_d = 3'(COUNTDOWN_START);
          timer_d     = '0;
          menu_act_d  = 1'b1;
        end
      end

      S_COUNTDOWN: begin
        if (timer_q == TW'(MENU_TIMER_CLK_COUNT - 1)) begin
          timer_d    = '0;
          menu_act_d = 1'b1;
          if (countdown_q <= 3'd1) begin
            state_d     = S_GAME;
            countdown_d = 3'd0;
          end else begin
            countdown_d = countdown_q - 3'd1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_GAME: begin
        accepted   = press & ready_q;
        activity_d = accepted;
        // Ascending scan: the first winning press found is the lowest index,
        // but every accepted press still moves its player.
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          if (accepted[i] && pos_q[i] != PW'(MAX_POS - 1)) begin
            pos_d[i] = pos_q[i] + PW'(1);
            if (pos_q[i] == PW'(MAX_POS - 2) && !win_found) begin
              win_found = 1'b1;
              winner_d  = WW'(i);
            end
          end
        end
        if (win_found) begin
          winner_valid_d = 1'b1;
          state_d        = S_END;
          timer_d        = '0;
          menu_act_d     = 1'b1;
        end
      end

      S_END: begin
        if (timer_q == TW'(END_TIMER_CLK_COUNT - 1)) begin
          state_d        = S_MENU;
          ready_d        = '0;
          pos_d          = '0;
          winner_d       = '0;
          winner_valid_d = 1'b0;
          countdown_d    = 3'd0;
          timer_d        = '0;
          menu_act_d     = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: state_d = S_MENU;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_MENU;
      ready_q        <= '0;
      pos_q          <= '0;
      countdown_q    <= 3'd0;
      winner_q       <= '0;
      winner_valid_q <= 1'b0;
      activity_q     <= '0;
      menu_act_q     <= 1'b0;
      timer_q        <= '0;
      // All ones: a button already held when reset releases is not a press.
      btn_prev_q     <= '1;
    end else begin
      state_q        <= state_d;
      ready_q        <= ready_d;
      pos_q          <= pos_d;
      countdown_q    <= countdown_d;
      winner_q       <= winner_d;
      winner_valid_q <= winner_valid_d;
      activity_q     <= activity_d;
      menu_act_q     <= menu_act_d;
      timer_q        <= timer_d;
      btn_prev_q     <= bus.btn;
    end
  end

  assign bus.ready         = ready_q;
  assign bus.cur_pos       = pos_q;
  assign bus.screen        = state_q;
  assign bus.countdown     = countdown_q;
  assign bus.winner        = winner_q;
  assign bus.winner_valid  = winner_valid_q;
  assign bus.activity      = activity_q;
  assign bus.menu_activity = menu_act_q;
endmodule

// File: tb/tb_race_domain_core.sv
// tb_race_domain_core: directed test of race_domain_core with
// NUM_PLAYERS=3, MAX_POS=4, MENU timer 4, END timer 8, countdown from 3.
module tb_race_domain_core;
  localparam int NP = 3;
  localparam int PW = 2;
  localparam int WW = 2;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  race_domain_if #(.NUM_PLAYERS(NP), .PW(PW), .WW(WW)) bus();

  race_domain_core #(
    .NUM_PLAYERS(NP),
    .MAX_POS(4),
    .MENU_TIMER_CLK_COUNT(4),
    .END_TIMER_CLK_COUNT(8),
    .COUNTDOWN_START(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_screen"}, 32'(bus.screen), 0);
    chk({tag, "_ready"}, 32'(bus.ready), 0);
    chk({tag, "_pos"}, 32'(bus.cur_pos), 0);
    chk({tag, "_cd"}, 32'(bus.countdown), 0);
    chk({tag, "_win"}, 32'(bus.winner), 0);
    chk({tag, "_wv"}, 32'(bus.winner_valid), 0);
  endtask

  initial begin
    reset   = 1'b0;
    bus.btn = 3'b010;
    tick(2);
    chk_idle("rst");
    chk("rst_act", 32'(bus.activity), 0);
    chk("rst_mact", 32'(bus.menu_activity), 0);
    reset = 1'b1;
    tick(3);
    chk("held_no_join", 32'(bus.ready), 0);
    chk("held_no_act", 32'(bus.activity), 0);

    // Race 1: P0 alone, timer-driven start
    bus.btn = 3'b011; tick(1);
    chk("r1_ready", 32'(bus.ready), 3'b001);
    chk("r1_act", 32'(bus.activity), 3'b001);
    bus.btn = 3'b010; tick(3);
    chk("r1_wait", 32'(bus.screen), 0);
    tick(1);
    chk("r1_cd_screen", 32'(bus.screen), 1);
    chk("r1_cd3", 32'(bus.countdown), 3);
    chk("r1_mact_cd", 32'(bus.menu_activity), 1);
    tick(1);
    chk("r1_mact_off", 32'(bus.menu_activity), 0);
    tick(2);
    chk("r1_cd3_hold", 32'(bus.countdown), 3);
    tick(1);
    chk("r1_cd2", 32'(bus.countdown), 2);
    chk("r1_mact_step", 32'(bus.menu_activity), 1);
    tick(4);
    chk("r1_cd1", 32'(bus.countdown), 1);
    bus.btn = 3'b110; tick(1);
    chk("r1_cd_frozen", 32'(bus.ready), 3'b001);
    chk("r1_cd_noact", 32'(bus.activity), 0);
    bus.btn = 3'b010; tick(2);
    chk("r1_still_cd", 32'(bus.screen), 1);
    tick(1);
    chk("r1_game", 32'(bus.screen), 2);
    chk("r1_game_cd0", 32'(bus.countdown), 0);

    bus.btn = 3'b000; tick(1);
    bus.btn = 3'b010; tick(1);
    chk("r1_p1_ignored", 32'(bus.cur_pos), 0);
    chk("r1_p1_noact", 32'(bus.activity), 0);
    for (int k = 1; k <= 2; k++) begin
      bus.btn = 3'b011; tick(1);
      chk("r1_p0_step", 32'(bus.cur_pos), 32'(k));
      chk("r1_p0_act", 32'(bus.activity), 3'b001);
      bus.btn = 3'b010; tick(1);
    end
    bus.btn = 3'b011; tick(1);
    chk("r1_win_pos", 32'(bus.cur_pos), 6'b000011);
    chk("r1_winner", 32'(bus.winner), 0);
    chk("r1_wv", 32'(bus.winner_valid), 1);
    chk("r1_end", 32'(bus.screen), 3);
    chk("r1_mact_end", 32'(bus.menu_activity), 1);
    bus.btn = 3'b010; tick(1);
    bus.btn = 3'b011; tick(1);
    chk("r1_end_pos_held", 32'(bus.cur_pos), 6'b000011);
    chk("r1_end_noact", 32'(bus.activity), 0);
    bus.btn = 3'b010; tick(5);
    chk("r1_end_hold", 32'(bus.screen), 3);
    chk("r1_end_wv", 32'(bus.winner_valid), 1);
    tick(1);
    chk_idle("soft");
    chk("soft_mact", 32'(bus.menu_activity), 1);

    // Race 2: staggered full lobby, simultaneous winning presses
    bus.btn = 3'b000; tick(1);
    bus.btn = 3'b001; tick(1);
    chk("r2_j0", 32'(bus.ready), 3'b001);
    bus.btn = 3'b000; tick(1);
    bus.btn = 3'b010; tick(1);
    chk("r2_j1", 32'(bus.ready), 3'b011);
    bus.btn = 3'b000; tick(1);
    bus.btn = 3'b100; tick(1);
    chk("r2_j2", 32'(bus.ready), 3'b111);
    chk("r2_j2_menu", 32'(bus.screen), 0);
    bus.btn = 3'b000; tick(1);
    chk("r2_fast_cd", 32'(bus.screen), 1);
    chk("r2_fast_cd3", 32'(bus.countdown), 3);
    tick(11);
    chk("r2_still_cd", 32'(bus.screen), 1);
    tick(1);
    chk("r2_game", 32'(bus.screen), 2);
    bus.btn = 3'b101; tick(1);
    chk("r2_pos1", 32'(bus.cur_pos), 6'b010001);
    chk("r2_act", 32'(bus.activity), 3'b101);
    bus.btn = 3'b000; tick(1);
    bus.btn = 3'b101; tick(1);
    chk("r2_pos2", 32'(bus.cur_pos), 6'b100010);
    bus.btn = 3'b000; tick(1);
    bus.btn = 3'b101; tick(1);
    chk("r2_tie_pos", 32'(bus.cur_pos), 6'b110011);
    chk("r2_tie_winner", 32'(bus.winner), 0);
    chk("r2_tie_wv", 32'(bus.winner_valid), 1);
    chk("r2_tie_end", 32'(bus.screen), 3);
    bus.btn = 3'b000; tick(8);
    chk("r2_menu", 32'(bus.screen), 0);

    // Race 3: reset mid-race with P1 held
    bus.btn = 3'b111; tick(1);
    chk("r3_join_all", 32'(bus.ready), 3'b111);
    chk("r3_act_all", 32'(bus.activity), 3'b111);
    bus.btn = 3'b000; tick(1);
    chk("r3_cd", 32'(bus.screen), 1);
    tick(12);
    chk("r3_game", 32'(bus.screen), 2);
    bus.btn = 3'b001; tick(1);
    bus.btn = 3'b000; tick(1);
    bus.btn = 3'b001; tick(1);
    chk("r3_pos2", 32'(bus.cur_pos), 6'b000010);
    bus.btn = 3'b010;
    reset   = 1'b0;
    #1;
    chk_idle("abort");
    chk("abort_act", 32'(bus.activity), 0);
    chk("abort_mact", 32'(bus.menu_activity), 0);
    tick(2);
    reset = 1'b1;
    tick(3);
    chk("r3_held_no_join", 32'(bus.ready), 0);
    chk("r3_held_no_act", 32'(bus.activity), 0);

    // Race 4: P2 alone wins, nonzero winner index
    bus.btn = 3'b110; tick(1);
    chk("r4_join", 32'(bus.ready), 3'b100);
    chk("r4_act", 32'(bus.activity), 3'b100);
    bus.btn = 3'b010; tick(4);
    chk("r4_cd", 32'(bus.screen), 1);
    tick(12);
    chk("r4_game", 32'(bus.screen), 2);
    repeat (2) begin
      bus.btn = 3'b110; tick(1);
      bus.btn = 3'b010; tick(1);
    end
    bus.btn = 3'b110; tick(1);
    chk("r4_pos", 32'(bus.cur_pos), 6'b110000);
    chk("r4_winner", 32'(bus.winner), 2);
    chk("r4_wv", 32'(bus.winner_valid), 1);
    chk("r4_end", 32'(bus.screen), 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
